// File: rtl/layer2_membrane_update_gen.sv
// layer2_membrane_update_gen: fetches layer-2 weight rows per layer-1 spike,
// accumulates signed per-lane sums over a timestep and emits them on done.
// Ports: clk, reset_n (async low); pre_spike_* valid/ready address input;
// timestep_done_i / this_sample_done_i control; weight_rd_* sync memory
// read port (data 1 cycle after en); membrane_update_o/_valid_o emit; busy_o.
// Option: LAYER2_UPDATE_SATURATE_EN selects saturating lane adds (else wrap).
module layer2_membrane_update_gen #(
  parameter int BIT_WIDTH_MEMBRANE = 16,
  parameter int BIT_WIDTH_WEIGHT   = 8,
  parameter int NEURON_NUM_IN_SET  = 20,
  parameter int BIT_WIDTH_PRE_ADDR = 8,
  parameter int PRE_NEURON_NUM     = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [BIT_WIDTH_PRE_ADDR-1:0] pre_spike_addr_i,
  input  logic pre_spike_valid_i,
  output logic pre_spike_ready_o,
  input  logic timestep_done_i,
  input  logic this_sample_done_i,
  output logic weight_rd_en_o,
  output logic [BIT_WIDTH_PRE_ADDR-1:0] weight_rd_addr_o,
  input  logic [BIT_WIDTH_WEIGHT*NEURON_NUM_IN_SET-1:0] weight_rd_data_i,
  output logic [BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET-1:0] membrane_update_o,
  output logic membrane_update_valid_o,
  output logic busy_o
);

  localparam int BM = BIT_WIDTH_MEMBRANE;
  localparam int BW = BIT_WIDTH_WEIGHT;
  localparam int N  = NEURON_NUM_IN_SET;
  localparam int AW = BIT_WIDTH_PRE_ADDR;
  localparam logic [AW:0] ADDR_LIM = (AW+1)'(PRE_NEURON_NUM);

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    EMIT
  } state_e;

  state_e state_q, state_d;
  logic pending_q, pending_d;
  logic valid_q, valid_d;
  logic [BM*N-1:0] upd_q, upd_d;
  logic signed [BM-1:0] acc_q [N];
  logic signed [BM-1:0] acc_d [N];
  logic signed [BM-1:0] acc_sum [N];
  logic fire;
  logic in_range;

  function automatic logic signed [BM-1:0] lane_add(
    input logic signed [BM-1:0] a,
    input logic signed [BW-1:0] w
  );
`ifdef LAYER2_UPDATE_SATURATE_EN
    logic signed [BM:0] s;
    s = {a[BM-1], a} + {{(BM-BW+1){w[BW-1]}}, w};
    // top two bits disagree only when the add left the BM-bit range
    if (s[BM] != s[BM-1]) begin
      lane_add = s[BM] ? {1'b1, {(BM-1){1'b0}}}
                       : {1'b0, {(BM-1){1'b1}}};
    end else begin
      lane_add = s[BM-1:0];
    end
`else
    lane_add = a + {{(BM-BW){w[BW-1]}}, w};
`endif
  endfunction

  assign pre_spike_ready_o = (state_q == ACCUM) && !this_sample_done_i;
  assign fire = pre_spike_valid_i && pre_spike_ready_o;
  assign in_range = {1'b0, pre_spike_addr_i} < ADDR_LIM;
  assign weight_rd_en_o = fire && in_range;
  assign weight_rd_addr_o = weight_rd_en_o ? pre_spike_addr_i : '0;
  assign membrane_update_o = upd_q;
  assign membrane_update_valid_o = valid_q;
  assign busy_o = (state_q != ACCUM) || pending_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_sum[i] = pending_q
        ? lane_add(acc_q[i], $signed(weight_rd_data_i[BW*i +: BW]))
        : acc_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pending_d = 1'b0;
    valid_d = 1'b0;
    upd_d = upd_q;
    for (int i = 0; i < N; i++) acc_d[i] = acc_q[i];
    if (this_sample_done_i) begin
      // abort: in-flight read data is dropped with the pending flag
      for (int i = 0; i < N; i++) acc_d[i] = '0;
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: begin
          for (int i = 0; i < N; i++) acc_d[i] = acc_sum[i];
          pending_d = weight_rd_en_o;
          if (timestep_done_i) state_d = DRAIN;
        end
        DRAIN: begin
          // last spike's row lands now; snapshot includes it
          for (int i = 0; i < N; i++) begin
            acc_d[i] = acc_sum[i];
            upd_d[BM*i +: BM] = acc_sum[i];
          end
          valid_d = 1'b1;
          state_d = EMIT;
        end
        EMIT: begin
          for (int i = 0; i < N; i++) acc_d[i] = '0;
          state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      pending_q <= 1'b0;
      valid_q <= 1'b0;
      upd_q <= '0;
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      valid_q <= valid_d;
      upd_q <= upd_d;
      for (int i = 0; i < N; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule

// File: tb/tb_layer2_membrane_update_gen.sv
// tb_layer2_membrane_update_gen: directed table, random traffic against a
// transaction-level model, and corner sequences for the update generator.
`timescale 1ns/1ps
module tb_layer2_membrane_update_gen;

  localparam int BM = 16;
  localparam int BW = 8;
  localparam int N  = 20;
  localparam int AW = 8;
  localparam int PN = 200;
  localparam int UW = BM*N;
  localparam int WW = BW*N;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic v_i = 1'b0;
  logic d_i = 1'b0;
  logic s_i = 1'b0;
  logic [AW-1:0] a_i = '0;
  logic ready, rd_en, valid, busy;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data = '0;
  logic [UW-1:0] upd;

  always #5 clk = ~clk;

  layer2_membrane_update_gen dut (
    .clk(clk),
    .reset_n(reset_n),
    .pre_spike_addr_i(a_i),
    .pre_spike_valid_i(v_i),
    .pre_spike_ready_o(ready),
    .timestep_done_i(d_i),
    .this_sample_done_i(s_i),
    .weight_rd_en_o(rd_en),
    .weight_rd_addr_o(rd_addr),
    .weight_rd_data_i(rd_data),
    .membrane_update_o(upd),
    .membrane_update_valid_o(valid),
    .busy_o(busy)
  );

  logic signed [BW-1:0] mem [PN][N];

  // synchronous weight memory; garbage on idle cycles
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_en) rd_data[BW*i +: BW] <= mem[rd_addr][i];
      else rd_data[BW*i +: BW] <= BW'($urandom);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [UW-1:0] act,
                     input logic [UW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // model: sums per lane of accepted spikes, timing by cycles-not-ready
  int blk = 0;
  bit prev_rd = 1'b0;
  int macc [N];
  int snap [N];
  logic [UW-1:0] last_vec = '0;
  logic s_ready, s_rden, s_valid;
  logic [UW-1:0] s_upd;

  function automatic int madd(input int a, input int w);
    int s;
    s = a + w;
`ifdef LAYER2_UPDATE_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    while (s > 32767) s -= 65536;
    while (s < -32768) s += 65536;
`endif
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) macc[i] = 0;
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] a,
                     input logic d, input logic s);
    logic er, ed, ev;
    v_i = v; a_i = a; d_i = d; s_i = s;
    er = (blk == 0) && !s;
    ed = v && er && (int'(a) < PN);
    ev = (blk == 1);
    if (ev)
      for (int i = 0; i < N; i++) last_vec[BM*i +: BM] = BM'(snap[i]);
    @(negedge clk);
    s_ready = ready; s_rden = rd_en; s_valid = valid; s_upd = upd;
    chk("ready", UW'(ready), UW'(er));
    chk("rd_en", UW'(rd_en), UW'(ed));
    chk("rd_addr", UW'(rd_addr), ed ? UW'(a) : '0);
    chk("valid", UW'(valid), UW'(ev));
    chk("busy", UW'(busy), UW'((blk != 0) || prev_rd));
    chk("update", upd, last_vec);
    if (ed)
      for (int i = 0; i < N; i++) macc[i] = madd(macc[i], int'(mem[a][i]));
    if (s) begin
      model_clear();
      blk = 0;
    end else if (blk > 0) begin
      blk--;
    end else if (d) begin
      for (int i = 0; i < N; i++) snap[i] = macc[i];
      model_clear();
      blk = 2;
    end
    prev_rd = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input int expv);
    logic [UW-1:0] e;
    for (int i = 0; i < N; i++) e[BM*i +: BM] = BM'(expv);
    chk(nm, s_upd, e);
    chk({nm, "_pulse"}, UW'(s_valid), UW'(1));
  endtask

  task automatic emit_seq();
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic v;
    logic [AW-1:0] a;
    logic d;
    logic s;
    logic er;
    logic ed;
    logic ev;
    int l0;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{1'b1, 8'd3,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 8'd5,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6};
    tbl[5]  = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    tbl[6]  = '{1'b1, 8'd250, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6};
    tbl[7]  = '{1'b1, 8'd7,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6};
    tbl[8]  = '{1'b1, 8'd7,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6};
    tbl[9]  = '{1'b1, 8'd7,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20};
    tbl[10] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20};
    tbl[11] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20};
    tbl[12] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20};
    tbl[13] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[14] = '{1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};

    for (int r = 0; r < PN; r++)
      for (int i = 0; i < N; i++) mem[r][i] = BW'($urandom);
    mem[3][0] = 8'sd10;
    mem[5][0] = -8'sd4;
    mem[7][0] = 8'sd20;
    model_clear();

    #1;
    chk("rst_ready", UW'(ready), UW'(1));
    chk("rst_rd_en", UW'(rd_en), '0);
    chk("rst_rd_addr", UW'(rd_addr), '0);
    chk("rst_update", upd, '0);
    chk("rst_valid", UW'(valid), '0);
    chk("rst_busy", UW'(busy), '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 15; k++) begin
      cyc(tbl[k].v, tbl[k].a, tbl[k].d, tbl[k].s);
      chk("tbl_ready", UW'(s_ready), UW'(tbl[k].er));
      chk("tbl_rd_en", UW'(s_rden), UW'(tbl[k].ed));
      chk("tbl_valid", UW'(s_valid), UW'(tbl[k].ev));
      chk("tbl_lane0", UW'(s_upd[BM-1:0]), UW'(BM'(tbl[k].l0)));
    end

    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 255)),
          $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
    end

    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) mem[0][i] = 8'sd127;
    repeat (200) cyc(1'b1, '0, 1'b0, 1'b0);
    emit_seq();
    chk_all("sum200", 25400);

    emit_seq();
    chk_all("empty", 0);

    emit_seq();
    cyc(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, '0, 1'b0, 1'b0);
    emit_seq();
    chk_all("sum3", 381);
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    emit_seq();
    chk_all("abort", 0);

    repeat (300) cyc(1'b1, '0, 1'b0, 1'b0);
    emit_seq();
`ifdef LAYER2_UPDATE_SATURATE_EN
    chk_all("sum300", 32767);
`else
    chk_all("sum300", -27436);
`endif

    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    v_i = 1'b0; d_i = 1'b0; s_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("drain_rst_valid", UW'(valid), '0);
    chk("drain_rst_update", upd, '0);
    chk("drain_rst_busy", UW'(busy), '0);
    chk("drain_rst_ready", UW'(ready), UW'(1));
    chk("drain_rst_rd_en", UW'(rd_en), '0);
    blk = 0; prev_rd = 1'b0; last_vec = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) cyc(1'b0, '0, 1'b0, 1'b0);
    emit_seq();
    chk_all("post_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer2_membrane_update_gen.md
# layer2_membrane_update_gen

Producer side of the layer-2 membrane-update interface. Accepts layer-1 presynaptic spike addresses one per cycle and fetches each address's layer-2 weight row from a synchronous weight memory. It accumulates per-neuron signed sums across a timestep and, on timestep end, emits the full update vector with a one-cycle valid pulse into the layer-2 neuron set.

## Interface
- BIT_WIDTH_MEMBRANE, 16, signed accumulator / update width per neuron
- BIT_WIDTH_WEIGHT, 8, signed weight width per neuron
- NEURON_NUM_IN_SET, 20, number of postsynaptic neurons (lanes)
- BIT_WIDTH_PRE_ADDR, 8, presynaptic address width
- PRE_NEURON_NUM, 200, valid address range 0..PRE_NEURON_NUM-1

Ports:
- clk  input  1  clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- pre_spike_addr_i  input  BIT_WIDTH_PRE_ADDR  presynaptic spike address
- pre_spike_valid_i  input  1  address valid
- pre_spike_ready_o  output  1  block accepts the address this cycle
- timestep_done_i  input  1  no more spikes this timestep; request emit
- this_sample_done_i  input  1  sample abort/clear
- weight_rd_en_o  output  1  weight memory read strobe
- weight_rd_addr_o  output  BIT_WIDTH_PRE_ADDR  weight row address
- weight_rd_data_i  input  BIT_WIDTH_WEIGHT*NEURON_NUM_IN_SET  row data, lane i at [BIT_WIDTH_WEIGHT*i +: BIT_WIDTH_WEIGHT], valid 1 cycle after rd_en
- membrane_update_o  output  BIT_WIDTH_MEMBRANE*NEURON_NUM_IN_SET  emitted update vector, lane i at [BIT_WIDTH_MEMBRANE*i +: BIT_WIDTH_MEMBRANE]
- membrane_update_valid_o  output  1  one-cycle emit pulse
- busy_o  output  1  state != ACCUM or read in flight

## Operation
- States: ACCUM, DRAIN, EMIT. Reset state ACCUM.
- pre_spike_ready_o = (state==ACCUM) && !this_sample_done_i. Handshake fires on valid && ready.
- Accepted address < PRE_NEURON_NUM: in the same cycle, weight_rd_en_o=1 and weight_rd_addr_o=address. Both are combinational from the handshake. A one-bit pending flag is registered.
- Accepted address >= PRE_NEURON_NUM: consumed and dropped, no read.
- pending=1: each lane acc[i] += sign-extended weight lane i. The accumulate happens at the edge that ends the data cycle.
- Throughput: one spike per cycle in ACCUM.
- ACCUM → DRAIN when timestep_done_i=1. A spike handshaking in the same cycle belongs to this timestep.
- DRAIN (1 cycle): final pending accumulate completes → EMIT.
- EMIT (1 cycle): membrane_update_valid_o=1 and membrane_update_o = acc (registered copy) → ACCUM. All acc are cleared at the end of the cycle.
- membrane_update_o holds the last emitted vector until the next EMIT.
- this_sample_done_i has highest priority in every state:
  - acc cleared, pending cleared, state → ACCUM, no emit.
  - Read data arriving next cycle is ignored.
  - Same-cycle timestep_done_i is ignored.
- timestep_done_i is ignored outside ACCUM.
- Empty timestep (no spikes) still emits an all-zero vector.

## Timing
- Reset values: pre_spike_ready_o=1 (combinational, reset state ACCUM), weight_rd_en_o=0, weight_rd_addr_o=0, membrane_update_o=0, membrane_update_valid_o=0, busy_o=0; acc=0, pending=0.
- Spike latency: handshake at cycle t, data at t+1, acc updated at end of t+1.
- Emit latency: timestep_done_i at cycle T → DRAIN at T+1 → membrane_update_valid_o=1 at T+2. The next spike is accepted at T+3.
- Async reset mid-operation: everything returns to reset values immediately; no partial emit.

## Configuration
- LAYER2_UPDATE_SATURATE_EN defined: each lane add saturates to [-2^(BIT_WIDTH_MEMBRANE-1), 2^(BIT_WIDTH_MEMBRANE-1)-1].
- LAYER2_UPDATE_SATURATE_EN undefined: two's-complement wrap-around at BIT_WIDTH_MEMBRANE bits.

## Test plan
- Spikes at addr 3, 5 (lane 0 weights +10, -4), then timestep_done → lane 0 update = 6. Valid pulses exactly 1 cycle, 2 cycles after done.
- 200 back-to-back spikes at addr 0 (all lanes weight +127), default widths:
  - saturate on: every lane = 25400.
  - Same stimulus with lane weight +127 and 300 spikes: saturate on → 32767; saturate off → wrapped value -27436.
- Spike at addr 7 coincident with timestep_done → included in emitted sum. pre_spike_ready_o low for 2 cycles after done.
- this_sample_done_i the cycle after a spike handshake (read in flight), then timestep_done → emitted vector all zeros.
- Spike at addr 250 (PRE_NEURON_NUM=200) → no weight_rd_en_o, accumulators unchanged.
- timestep_done with no spikes → zero vector emitted. reset_n low during DRAIN → no valid pulse, outputs 0.
